circular_op_quadrant_tracker: RTL

Sequential successor to the combinational quadrant finder. Used by the circular-op handler to track an arc's progress. For each arc, the block latches the start and end points (relative to the circle centre) and the direction. It then consumes a stream of relative positions and emits, per sample, the quadrant, a crossing flag, a running crossing count and an arc-end-reached flag. All outputs pass through one registered valid/ready stage.

---
 rtl/circular_op_quadrant_tracker_pkg.sv | 14 +
 rtl/circular_op_quadrant_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/circular_op_quadrant_tracker_pkg.sv
// Shared types and widths for the circular-op quadrant tracker.
package circular_op_quadrant_tracker_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned COUNT_W   = 3;

    typedef enum logic [1:0] {
        POS_QUADRANT_1 = 2'd0,
        POS_QUADRANT_2 = 2'd1,
        POS_QUADRANT_3 = 2'd2,
        POS_QUADRANT_4 = 2'd3
    } PosQuadrant_t;

endpackage

// File: rtl/circular_op_quadrant_tracker.sv
// Tracks an arc's progress through the quadrants, one registered valid/ready output stage.
// Optional sticky illegal-transition flag: define CIRCULAR_QUADRANT_TRACKER_ERROR_EN.
module circular_op_quadrant_tracker
    import circular_op_quadrant_tracker_pkg::*;
#(
    parameter int unsigned NUM_BITS = BYTE_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] start_x,
    input  logic [NUM_BITS-1:0] start_y,
    input  logic [NUM_BITS-1:0] end_x,
    input  logic [NUM_BITS-1:0] end_y,
    input  logic                is_cw,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] relative_x,
    input  logic [NUM_BITS-1:0] relative_y,
    output logic                out_valid,
    input  logic                out_ready,
    output PosQuadrant_t        quadrant,
    output logic                crossed,
    output logic [COUNT_W-1:0]  crossing_count,
    output logic                reached,
    output logic                busy,
    output logic                error
);

    localparam int unsigned PROD_W  = 2 * NUM_BITS;
    localparam int unsigned CROSS_W = PROD_W + 1;
    localparam logic [COUNT_W-1:0] FULL_TURN = COUNT_W'(4);

    typedef enum logic {
        ST_IDLE,
        ST_TRACK
    } state_t;

    function automatic PosQuadrant_t quad_of(input logic x_neg, input logic y_neg);
        case ({x_neg, y_neg})
            2'b00:   return POS_QUADRANT_1;
            2'b10:   return POS_QUADRANT_2;
            2'b11:   return POS_QUADRANT_3;
            default: return POS_QUADRANT_4;
        endcase
    endfunction

    state_t               state_q, state_d;
    PosQuadrant_t         q_e_q, q_e_d;
    PosQuadrant_t         prev_q_q, prev_q_d;
    PosQuadrant_t         quadrant_q, quadrant_d;
    logic [COUNT_W-1:0]   req_q, req_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 is_cw_q, is_cw_d;
    logic                 out_valid_q, out_valid_d;
    logic                 crossed_q, crossed_d;
    logic                 reached_q, reached_d;

    logic                        in_ready_c;
    logic                        accept_c;
    PosQuadrant_t                q_start_c, q_end_c, q_samp_c;
    logic [1:0]                  arc_diff_c;
    logic [1:0]                  step_c;
    logic [1:0]                  samp_diff_c;
    logic                        step_ok_c;
    logic [COUNT_W-1:0]          count_next_c;
    logic [COUNT_W-1:0]          req_c;
    logic signed [NUM_BITS-1:0]  sx_c, sy_c, ex_c, ey_c;
    logic signed [PROD_W-1:0]    prod_a_c, prod_b_c;
    logic signed [CROSS_W-1:0]   cross_c;
    logic                        same_pt_c;
    logic                        long_way_c;
    logic                        unused_mag_c;

    // Only the sign bits of the sample position matter for the quadrant.
    assign unused_mag_c = ^{relative_x[NUM_BITS-2:0], relative_y[NUM_BITS-2:0]};

    assign in_ready_c = (state_q == ST_TRACK) & ~start & (~out_valid_q | out_ready);
    assign accept_c   = in_valid & in_ready_c;

    // Arc setup: quadrants of the endpoints and the number of crossings to reach the end.
    always_comb begin
        q_start_c = quad_of(start_x[NUM_BITS-1], start_y[NUM_BITS-1]);
        q_end_c   = quad_of(end_x[NUM_BITS-1], end_y[NUM_BITS-1]);
        sx_c      = start_x;
        sy_c      = start_y;
        ex_c      = end_x;
        ey_c      = end_y;
        prod_a_c  = PROD_W'(sx_c) * PROD_W'(ey_c);
        prod_b_c  = PROD_W'(sy_c) * PROD_W'(ex_c);
        cross_c   = CROSS_W'(prod_a_c) - CROSS_W'(prod_b_c);
        same_pt_c = (start_x == end_x) && (start_y == end_y);
        arc_diff_c = is_cw ? 2'(q_start_c - q_end_c) : 2'(q_end_c - q_start_c);
        // Same quadrant: the cross product tells a short arc from a near-full turn.
        long_way_c = same_pt_c
                   || (!is_cw && cross_c[CROSS_W-1])
                   || (is_cw && !cross_c[CROSS_W-1] && (cross_c != '0));
        req_c = '0;
        if (arc_diff_c != 2'd0) begin
            req_c = COUNT_W'(arc_diff_c);
        end else if (long_way_c) begin
            req_c = FULL_TURN;
        end
    end

    // Per-sample step classification against the previous quadrant.
    always_comb begin
        q_samp_c     = quad_of(relative_x[NUM_BITS-1], relative_y[NUM_BITS-1]);
        step_c       = is_cw_q ? 2'd3 : 2'd1;
        samp_diff_c  = 2'(q_samp_c - prev_q_q);
        step_ok_c    = (samp_diff_c == step_c);
        count_next_c = count_q;
        if (step_ok_c && (count_q < FULL_TURN)) begin
            count_next_c = count_q + COUNT_W'(1);
        end
    end

`ifdef CIRCULAR_QUADRANT_TRACKER_ERROR_EN
    logic error_q, error_d;
    logic illegal_c;
    assign illegal_c = (samp_diff_c != 2'd0) && !step_ok_c;
    assign error     = error_q;
`else
    assign error = 1'b0;
`endif

    // Next-state and output-stage update.
    always_comb begin
        state_d     = state_q;
        q_e_d       = q_e_q;
        prev_q_d    = prev_q_q;
        quadrant_d  = quadrant_q;
        req_d       = req_q;
        count_d     = count_q;
        is_cw_d     = is_cw_q;
        out_valid_d = out_valid_q;
        crossed_d   = crossed_q;
        reached_d   = reached_q;
`ifdef CIRCULAR_QUADRANT_TRACKER_ERROR_EN
        error_d     = error_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!start && out_valid_q && out_ready && reached_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            q_e_d       = q_end_c;
            req_d       = req_c;
            prev_q_d    = q_start_c;
            is_cw_d     = is_cw;
            count_d     = '0;
            out_valid_d = 1'b0;
`ifdef CIRCULAR_QUADRANT_TRACKER_ERROR_EN
            error_d     = 1'b0;
`endif
        end else if (accept_c) begin
            prev_q_d    = q_samp_c;
            quadrant_d  = q_samp_c;
            crossed_d   = step_ok_c;
            count_d     = count_next_c;
            reached_d   = (count_next_c == req_q) && (q_samp_c == q_e_q);
            out_valid_d = 1'b1;
`ifdef CIRCULAR_QUADRANT_TRACKER_ERROR_EN
            error_d     = error_q | illegal_c;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            q_e_q       <= POS_QUADRANT_1;
            prev_q_q    <= POS_QUADRANT_1;
            quadrant_q  <= POS_QUADRANT_1;
            req_q       <= '0;
            count_q     <= '0;
            is_cw_q     <= 1'b0;
            out_valid_q <= 1'b0;
            crossed_q   <= 1'b0;
            reached_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_e_q       <= q_e_d;
            prev_q_q    <= prev_q_d;
            quadrant_q  <= quadrant_d;
            req_q       <= req_d;
            count_q     <= count_d;
            is_cw_q     <= is_cw_d;
            out_valid_q <= out_valid_d;
            crossed_q   <= crossed_d;
            reached_q   <= reached_d;
        end
    end

`ifdef CIRCULAR_QUADRANT_TRACKER_ERROR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`endif

    assign in_ready       = in_ready_c;
    assign out_valid      = out_valid_q;
    assign quadrant       = quadrant_q;
    assign crossed        = crossed_q;
    assign crossing_count = count_q;
    assign reached        = reached_q;
    assign busy           = (state_q == ST_TRACK);

endmodule
